// File: rtl/rgbw_frame_decoder_pkg.sv
// rtl/rgbw_frame_decoder_pkg.sv - shared states, command codes and channel indices for the RGBW frame decoder
package rgbw_frame_decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_COL   = 3'd2,
    ST_PWR   = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam logic [7:0]  DEF_CMD_COLOUR  = 8'hA5;
  localparam logic [7:0]  DEF_CMD_POWER   = 8'h5A;
  localparam int unsigned DEF_TIMEOUT_CYC = 12000;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;
  localparam logic [1:0] CH_W = 2'd3;

  // A frame is "in progress" once the header is awaited and until it is either committed or abandoned.
  function automatic logic is_frame_state(input state_t s);
    return (s == ST_HDR) || (s == ST_COL) || (s == ST_PWR);
  endfunction

endpackage

// File: rtl/rgbw_frame_decoder_cs_sync.sv
// rtl/rgbw_frame_decoder_cs_sync.sv - 2-FF synchroniser with one-cycle rise/fall pulses for an asynchronous pin
module rgbw_frame_decoder_cs_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Two flops to resolve metastability, a third holds the previous synchronised level for edge detection.
  // Reset to 1 because the pin idles high (chip select deasserted).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/rgbw_frame_decoder.sv
// rtl/rgbw_frame_decoder.sv - parses CS-delimited SPI frames into committed RGBW duties and power enables
module rgbw_frame_decoder
  import rgbw_frame_decoder_pkg::*;
#(
  parameter logic [7:0]  CMD_COLOUR  = DEF_CMD_COLOUR,
  parameter logic [7:0]  CMD_POWER   = DEF_CMD_POWER,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic       clk12,
  input  logic       reset,
  input  logic       cs,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic [7:0] white,
  output logic [3:0] pwr_en,
  output logic       upd,
  output logic       frame_err,
  output logic       dbg
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  logic       w_cs_rise;
  logic       w_cs_fall;

  state_t     r_state;
  state_t     w_state_next;
  logic       w_commit_col;
  logic       w_commit_pwr;
  logic       w_store;
  logic       w_err_set;
  logic       w_hdr_entry;
  logic       w_col_entry;
  logic       w_timeout;

  logic [1:0]  r_idx;
  logic [7:0]  r_shadow_r;
  logic [7:0]  r_shadow_g;
  logic [7:0]  r_shadow_b;
  logic [15:0] r_cnt;

  logic [7:0] r_red;
  logic [7:0] r_green;
  logic [7:0] r_blue;
  logic [7:0] r_white;
  logic [3:0] r_pwr_en;
  logic       r_upd;
  logic       r_frame_err;

  rgbw_frame_decoder_cs_sync u_cs_sync (
    .i_clk   (clk12),
    .i_reset (reset),
    .i_async (cs),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  assign w_timeout = (r_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk12) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and per-cycle actions. cs_rise is tested first so a byte coinciding with it is dropped;
  // a received byte is tested before the timeout because it restarts the inter-byte interval.
  always_comb begin
    w_state_next = r_state;
    w_commit_col = 1'b0;
    w_commit_pwr = 1'b0;
    w_store      = 1'b0;
    w_err_set    = 1'b0;
    w_hdr_entry  = 1'b0;
    w_col_entry  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_next = ST_HDR;
          w_hdr_entry  = 1'b1;
        end
      end
      ST_HDR: begin
        if (w_cs_rise) begin
          w_state_next = ST_IDLE;
        end else if (rx_rdy) begin
          if (rx_data == CMD_COLOUR) begin
            w_state_next = ST_COL;
            w_col_entry  = 1'b1;
          end else if (rx_data == CMD_POWER) begin
            w_state_next = ST_PWR;
          end else begin
            w_state_next = ST_DRAIN;
            w_err_set    = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_next = ST_DRAIN;
          w_err_set    = 1'b1;
        end
      end
      ST_COL: begin
        if (w_cs_rise) begin
          w_state_next = ST_IDLE;
          w_err_set    = 1'b1;
        end else if (rx_rdy) begin
          if (r_idx == CH_W) begin
            w_state_next = ST_DRAIN;
            w_commit_col = 1'b1;
          end else begin
            w_store = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_next = ST_DRAIN;
          w_err_set    = 1'b1;
        end
      end
      ST_PWR: begin
        if (w_cs_rise) begin
          w_state_next = ST_IDLE;
          w_err_set    = 1'b1;
        end else if (rx_rdy) begin
          w_state_next = ST_DRAIN;
          w_commit_pwr = 1'b1;
        end else if (w_timeout) begin
          w_state_next = ST_DRAIN;
          w_err_set    = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (w_cs_rise) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Payload index and shadow bytes; the fourth byte goes straight to the white output, so only three shadows.
  always_ff @(posedge clk12) begin
    if (reset) begin
      r_idx      <= CH_R;
      r_shadow_r <= 8'h00;
      r_shadow_g <= 8'h00;
      r_shadow_b <= 8'h00;
    end else if (w_col_entry) begin
      r_idx <= CH_R;
    end else if (w_store) begin
      r_idx <= r_idx + 2'd1;
      case (r_idx)
        CH_R:    r_shadow_r <= rx_data;
        CH_G:    r_shadow_g <= rx_data;
        default: r_shadow_b <= rx_data;
      endcase
    end
  end

  // Inter-byte timeout counter; saturates at its terminal value so it can never wrap back into range.
  always_ff @(posedge clk12) begin
    if (reset) begin
      r_cnt <= 16'd0;
    end else if (rx_rdy || w_hdr_entry) begin
      r_cnt <= 16'd0;
    end else if (is_frame_state(r_state) && (r_cnt != CNT_LAST)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Committed outputs: only a completed frame or reset changes them; the error flag is sticky until a commit.
  always_ff @(posedge clk12) begin
    if (reset) begin
      r_red       <= 8'h00;
      r_green     <= 8'h00;
      r_blue      <= 8'h00;
      r_white     <= 8'h00;
      r_pwr_en    <= 4'h0;
      r_upd       <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_upd <= w_commit_col | w_commit_pwr;
      if (w_commit_col) begin
        r_red   <= r_shadow_r;
        r_green <= r_shadow_g;
        r_blue  <= r_shadow_b;
        r_white <= rx_data;
      end
      if (w_commit_pwr) begin
        r_pwr_en <= rx_data[3:0];
      end
      if (w_commit_col || w_commit_pwr) begin
        r_frame_err <= 1'b0;
      end else if (w_err_set) begin
        r_frame_err <= 1'b1;
      end
    end
  end

  assign red       = r_red;
  assign green     = r_green;
  assign blue      = r_blue;
  assign white     = r_white;
  assign pwr_en    = r_pwr_en;
  assign upd       = r_upd;
  assign frame_err = r_frame_err;
  assign dbg       = is_frame_state(r_state);

endmodule

// File: tb/tb_rgbw_frame_decoder.sv
// tb/tb_rgbw_frame_decoder.sv - directed self-checking bench for rgbw_frame_decoder
module tb_rgbw_frame_decoder;

  logic       clk12;
  logic       reset;
  logic       cs;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic [7:0] white;
  logic [3:0] pwr_en;
  logic       upd;
  logic       frame_err;
  logic       dbg;

  int n_checks;
  int n_fail;
  int upd_cnt;

  rgbw_frame_decoder dut (
    .clk12     (clk12),
    .reset     (reset),
    .cs        (cs),
    .rx_rdy    (rx_rdy),
    .rx_data   (rx_data),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .white     (white),
    .pwr_en    (pwr_en),
    .upd       (upd),
    .frame_err (frame_err),
    .dbg       (dbg)
  );

  initial clk12 = 1'b0;
  always #5 clk12 = ~clk12;

  always @(negedge clk12) begin
    if (upd === 1'b1) upd_cnt = upd_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk12);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk12);
    #1;
    rx_rdy  = 1'b1;
    rx_data = b;
    @(posedge clk12);
    #1;
    rx_rdy  = 1'b0;
    tick(2);
  endtask

  task automatic cs_low();
    cs = 1'b0;
    tick(5);
  endtask

  task automatic cs_high();
    cs = 1'b1;
    tick(5);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    n_checks++;
    if ({red, green, blue, white} !== 32'h0) begin
      n_fail++; $display("FAIL reset_colours: got %h expected 00000000", {red, green, blue, white});
    end
    n_checks++;
    if ({pwr_en, upd, frame_err, dbg} !== 7'b0) begin
      n_fail++; $display("FAIL reset_flags: pwr_en=%h upd=%b err=%b dbg=%b expected all 0", pwr_en, upd, frame_err, dbg);
    end
  endtask

  task automatic test_colour_frame();
    int u0;
    int u_mid;
    u0 = upd_cnt;
    cs_low();
    n_checks++;
    if (dbg !== 1'b1) begin
      n_fail++; $display("FAIL colour_dbg_hdr: got %b expected 1", dbg);
    end
    send_byte(8'hA5);
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h30);
    n_checks++;
    if ({red, green, blue, white} !== 32'h0 || upd_cnt != u0) begin
      n_fail++; $display("FAIL colour_no_early_commit: got %h upd=%0d expected 00000000 upd=0", {red, green, blue, white}, upd_cnt - u0);
    end
    u_mid = upd_cnt;
    send_byte(8'h40);
    n_checks++;
    if ({red, green, blue, white} !== 32'h10203040) begin
      n_fail++; $display("FAIL colour_commit: got %h expected 10203040", {red, green, blue, white});
    end
    n_checks++;
    if (upd_cnt - u_mid != 1) begin
      n_fail++; $display("FAIL colour_upd_pulse: got %0d cycles expected 1", upd_cnt - u_mid);
    end
    cs_high();
    n_checks++;
    if (dbg !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL colour_end_state: dbg=%b err=%b expected 0 0", dbg, frame_err);
    end
  endtask

  task automatic test_abort_then_power();
    int u0;
    u0 = upd_cnt;
    cs_low();
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h22);
    cs_high();
    n_checks++;
    if ({red, green, blue, white} !== 32'h10203040) begin
      n_fail++; $display("FAIL abort_colours_hold: got %h expected 10203040", {red, green, blue, white});
    end
    n_checks++;
    if (frame_err !== 1'b1 || upd_cnt != u0) begin
      n_fail++; $display("FAIL abort_err: err=%b upd=%0d expected 1 0", frame_err, upd_cnt - u0);
    end
    cs_low();
    send_byte(8'h5A);
    send_byte(8'hFF);
    cs_high();
    n_checks++;
    if (pwr_en !== 4'hF || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL power_commit: pwr_en=%h err=%b expected f 0", pwr_en, frame_err);
    end
  endtask

  task automatic test_bad_header();
    cs_low();
    send_byte(8'h33);
    send_byte(8'h5A);
    send_byte(8'h01);
    n_checks++;
    if (frame_err !== 1'b1 || pwr_en !== 4'hF || dbg !== 1'b0) begin
      n_fail++; $display("FAIL bad_header: err=%b pwr_en=%h dbg=%b expected 1 f 0", frame_err, pwr_en, dbg);
    end
    cs_high();
    cs_low();
    send_byte(8'h5A);
    send_byte(8'h01);
    cs_high();
    n_checks++;
    if (pwr_en !== 4'h1 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL bad_header_recover: pwr_en=%h err=%b expected 1 0", pwr_en, frame_err);
    end
  endtask

  task automatic test_timeout();
    int u0;
    u0 = upd_cnt;
    cs_low();
    send_byte(8'hA5);
    @(posedge clk12);
    #1;
    rx_rdy  = 1'b1;
    rx_data = 8'h01;
    @(posedge clk12);
    #1;
    rx_rdy  = 1'b0;
    tick(11990);
    n_checks++;
    if (dbg !== 1'b1 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_early: dbg=%b err=%b expected 1 0", dbg, frame_err);
    end
    tick(20);
    n_checks++;
    if (dbg !== 1'b0 || frame_err !== 1'b1) begin
      n_fail++; $display("FAIL timeout_drain: dbg=%b err=%b expected 0 1", dbg, frame_err);
    end
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    n_checks++;
    if ({red, green, blue, white} !== 32'h10203040 || upd_cnt != u0 || frame_err !== 1'b1) begin
      n_fail++; $display("FAIL timeout_ignore: got %h upd=%0d err=%b expected 10203040 0 1", {red, green, blue, white}, upd_cnt - u0, frame_err);
    end
    cs_high();
  endtask

  task automatic test_reset_mid_frame();
    int u0;
    cs_low();
    send_byte(8'hA5);
    send_byte(8'h01);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    n_checks++;
    if ({red, green, blue, white} !== 32'h0 || pwr_en !== 4'h0 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL midreset_values: got %h pwr_en=%h err=%b expected 00000000 0 0", {red, green, blue, white}, pwr_en, frame_err);
    end
    u0 = upd_cnt;
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    cs_high();
    n_checks++;
    if ({red, green, blue, white} !== 32'h0 || upd_cnt != u0) begin
      n_fail++; $display("FAIL midreset_no_commit: got %h upd=%0d expected 00000000 0", {red, green, blue, white}, upd_cnt - u0);
    end
  endtask

  task automatic test_rise_collision();
    int u0;
    cs_low();
    send_byte(8'h5A);
    u0 = upd_cnt;
    cs = 1'b1;
    tick(2);
    rx_rdy  = 1'b1;
    rx_data = 8'h03;
    tick(1);
    rx_rdy  = 1'b0;
    tick(4);
    n_checks++;
    if (pwr_en !== 4'h0 || upd_cnt != u0 || frame_err !== 1'b1 || dbg !== 1'b0) begin
      n_fail++; $display("FAIL rise_collision: pwr_en=%h upd=%0d err=%b dbg=%b expected 0 0 1 0", pwr_en, upd_cnt - u0, frame_err, dbg);
    end
  endtask

  task automatic test_back_to_back();
    int u0;
    u0 = upd_cnt;
    cs_low();
    send_byte(8'h5A);
    send_byte(8'hF6);
    cs_high();
    cs_low();
    send_byte(8'hA5);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    send_byte(8'hEE);
    cs_high();
    n_checks++;
    if (pwr_en !== 4'h6 || {red, green, blue, white} !== 32'hAABBCCDD) begin
      n_fail++; $display("FAIL back_to_back: pwr_en=%h colours=%h expected 6 aabbccdd", pwr_en, {red, green, blue, white});
    end
    n_checks++;
    if (upd_cnt - u0 != 2 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL back_to_back_upd: upd=%0d err=%b expected 2 0", upd_cnt - u0, frame_err);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    upd_cnt  = 0;
    reset    = 1'b1;
    cs       = 1'b1;
    rx_rdy   = 1'b0;
    rx_data  = 8'h00;
    test_reset();
    test_colour_frame();
    test_abort_then_power();
    test_bad_header();
    test_timeout();
    test_reset_mid_frame();
    test_rise_collision();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
